// File: rtl/apb_demux_ctrl.sv
// -----------------------------------------------------------------------------
// apb_demux_ctrl
//
// Registered APB demultiplexer. One upstream APB completer port is decoded
// against per-slave base/mask windows. The transfer is then replayed on one of
// SLAVE_COUNT downstream APB requester ports with a full SETUP/ACCESS sequence.
// Read data and error from the selected slave are returned upstream as a
// single-cycle response.
//
// The block answers on its own with an error response for:
//   - addresses that match no window;
//   - slaves that hold PREADY low for TIMEOUT ACCESS cycles (0 disables this).
//
// Ports
//   clk_i, rst_i             clock; asynchronous active-high reset
//   s_psel_i .. s_pwdata_i   upstream request (s_penable_i is not used)
//   s_pready_o               one-cycle completion pulse per transfer
//   s_prdata_o, s_pslverr_o  response, valid only while s_pready_o is high,
//                            zero at all other times
//   m_psel_o                 downstream selects, one-hot or zero
//   m_penable_o              shared downstream enable
//   m_paddr_o, m_pwrite_o,   broadcast request fields; they keep the value of
//   m_pwdata_o               the last transfer between transfers
//   m_pready_i, m_prdata_i,  per-slave responses; m_prdata_i is packed with
//   m_pslverr_i              slave k at [k*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module apb_demux_ctrl #(
  parameter int SLAVE_COUNT = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK =
    {3{32'hFFFF_F000}},
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  // upstream completer port
  input  logic                              s_psel_i,
  input  logic                              s_penable_i,
  input  logic [ADDR_WIDTH-1:0]             s_paddr_i,
  input  logic                              s_pwrite_i,
  input  logic [DATA_WIDTH-1:0]             s_pwdata_i,
  output logic                              s_pready_o,
  output logic [DATA_WIDTH-1:0]             s_prdata_o,
  output logic                              s_pslverr_o,
  // downstream requester ports
  output logic [SLAVE_COUNT-1:0]            m_psel_o,
  output logic                              m_penable_o,
  output logic [ADDR_WIDTH-1:0]             m_paddr_o,
  output logic                              m_pwrite_o,
  output logic [DATA_WIDTH-1:0]             m_pwdata_o,
  input  logic [SLAVE_COUNT-1:0]            m_pready_i,
  input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] m_prdata_i,
  input  logic [SLAVE_COUNT-1:0]            m_pslverr_i
);

  localparam int IDX_W     = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
  // The per-slave response arrays are padded to a power of two so that every
  // value of the index register addresses a defined (zero) entry.
  localparam int PAD_COUNT = 1 << IDX_W;
  localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                  state_reg;
  logic [IDX_W-1:0]        sel_idx_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;
  logic [SLAVE_COUNT-1:0]  m_psel_reg;
  logic                    m_penable_reg;
  logic [ADDR_WIDTH-1:0]   m_paddr_reg;
  logic                    m_pwrite_reg;
  logic [DATA_WIDTH-1:0]   m_pwdata_reg;
  logic                    s_pready_reg;
  logic [DATA_WIDTH-1:0]   s_prdata_reg;
  logic                    s_pslverr_reg;

  // Upstream PENABLE carries no information for this block: the request is
  // taken on PSEL alone and the master holds it stable until PREADY.
  logic unused_penable;
  assign unused_penable = s_penable_i;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [SLAVE_COUNT-1:0] hit_vec;
  logic [IDX_W-1:0]       hit_idx;
  logic                   hit_any;
  logic [SLAVE_COUNT-1:0] hit_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < SLAVE_COUNT; gi++) begin : g_decode
      assign hit_vec[gi] =
        (s_paddr_i & SLAVE_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]) ==
        SLAVE_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Scan from the top down so the lowest hitting index is the one that sticks
  // when windows overlap.
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int k = SLAVE_COUNT - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        hit_idx = IDX_W'(k);
        hit_any = 1'b1;
      end
    end
  end

  assign hit_onehot = SLAVE_COUNT'(1) << hit_idx;

  // ---------------------------------------------------------------------------
  // Per-slave response unpacking and selection
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] slave_rdata [PAD_COUNT];
  logic [PAD_COUNT-1:0]  slave_ready;
  logic [PAD_COUNT-1:0]  slave_err;

  generate
    for (gi = 0; gi < PAD_COUNT; gi++) begin : g_unpack
      if (gi < SLAVE_COUNT) begin : g_real
        assign slave_rdata[gi] = m_prdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign slave_ready[gi] = m_pready_i[gi];
        assign slave_err[gi]   = m_pslverr_i[gi];
      end else begin : g_pad
        assign slave_rdata[gi] = '0;
        assign slave_ready[gi] = 1'b0;
        assign slave_err[gi]   = 1'b0;
      end
    end
  endgenerate

  // Only the latched slave is looked at; PREADY from the others is ignored.
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign sel_ready = slave_ready[sel_idx_reg];
  assign sel_err   = slave_err[sel_idx_reg];
  assign sel_rdata = slave_rdata[sel_idx_reg];

  // ---------------------------------------------------------------------------
  // ACCESS-phase timeout
  // ---------------------------------------------------------------------------
  // count_reg holds the number of completed ACCESS cycles without ready. The
  // abort fires at the end of the cycle that brings the count to TIMEOUT, so
  // ACCESS lasts exactly TIMEOUT cycles.
  logic timeout_hit;

  assign count_next  = count_reg + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (count_next == TIMEOUT_CNT);

  // ---------------------------------------------------------------------------
  // Transfer FSM, all outputs registered
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      sel_idx_reg   <= '0;
      count_reg     <= '0;
      m_psel_reg    <= '0;
      m_penable_reg <= 1'b0;
      m_paddr_reg   <= '0;
      m_pwrite_reg  <= 1'b0;
      m_pwdata_reg  <= '0;
      s_pready_reg  <= 1'b0;
      s_prdata_reg  <= '0;
      s_pslverr_reg <= 1'b0;
    end else begin
      // The response is a one-cycle pulse; everything clears unless the
      // branch below loads a new response.
      s_pready_reg  <= 1'b0;
      s_prdata_reg  <= '0;
      s_pslverr_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (s_psel_i) begin
            m_paddr_reg  <= s_paddr_i;
            m_pwrite_reg <= s_pwrite_i;
            m_pwdata_reg <= s_pwdata_i;
            if (hit_any) begin
              sel_idx_reg <= hit_idx;
              m_psel_reg  <= hit_onehot;
              state_reg   <= SETUP;
            end else begin
              // Unmapped address: answer directly, no slave is touched.
              s_pready_reg  <= 1'b1;
              s_pslverr_reg <= 1'b1;
              state_reg     <= RESP;
            end
          end
        end

        SETUP: begin
          m_penable_reg <= 1'b1;
          count_reg     <= '0;
          state_reg     <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            m_psel_reg    <= '0;
            m_penable_reg <= 1'b0;
            s_pready_reg  <= 1'b1;
            // Write responses carry no data, whatever the slave drives.
            s_prdata_reg  <= m_pwrite_reg ? '0 : sel_rdata;
            s_pslverr_reg <= sel_err;
            state_reg     <= RESP;
          end else if (timeout_hit) begin
            m_psel_reg    <= '0;
            m_penable_reg <= 1'b0;
            s_pready_reg  <= 1'b1;
            s_pslverr_reg <= 1'b1;
            count_reg     <= count_next;
            state_reg     <= RESP;
          end else if (TIMEOUT != 0) begin
            count_reg <= count_next;
          end
        end

        RESP: begin
          // s_pready_o is high during this cycle; the next request can be
          // sampled in the IDLE cycle that follows.
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign m_psel_o    = m_psel_reg;
  assign m_penable_o = m_penable_reg;
  assign m_paddr_o   = m_paddr_reg;
  assign m_pwrite_o  = m_pwrite_reg;
  assign m_pwdata_o  = m_pwdata_reg;
  assign s_pready_o  = s_pready_reg;
  assign s_prdata_o  = s_prdata_reg;
  assign s_pslverr_o = s_pslverr_reg;

  // Structural invariants of the downstream and upstream handshakes.
  a_psel_onehot0 : assert property (
    @(posedge clk_i) disable iff (rst_i) $onehot0(m_psel_reg));
  a_pready_pulse : assert property (
    @(posedge clk_i) disable iff (rst_i) s_pready_reg |=> !s_pready_reg);

endmodule

// File: tb/tb_apb_demux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_demux_ctrl
//
// Directed bench for apb_demux_ctrl with default parameters (3 slaves,
// 4 KiB windows at 0x0000/0x1000/0x2000, TIMEOUT=16).
// Each issued transfer pushes its expected response (data, error and the
// cycle in which s_pready_o must appear) into a queue. A separate monitor
// pops and compares whenever s_pready_o is high.
// -----------------------------------------------------------------------------
module tb_apb_demux_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        s_psel_i;
  logic        s_penable_i;
  logic [31:0] s_paddr_i;
  logic        s_pwrite_i;
  logic [31:0] s_pwdata_i;
  logic        s_pready_o;
  logic [31:0] s_prdata_o;
  logic        s_pslverr_o;
  logic [2:0]  m_psel_o;
  logic        m_penable_o;
  logic [31:0] m_paddr_o;
  logic        m_pwrite_o;
  logic [31:0] m_pwdata_o;
  logic [2:0]  m_pready_i;
  logic [95:0] m_prdata_i;
  logic [2:0]  m_pslverr_i;

  apb_demux_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_psel_i    (s_psel_i),
    .s_penable_i (s_penable_i),
    .s_paddr_i   (s_paddr_i),
    .s_pwrite_i  (s_pwrite_i),
    .s_pwdata_i  (s_pwdata_i),
    .s_pready_o  (s_pready_o),
    .s_prdata_o  (s_prdata_o),
    .s_pslverr_o (s_pslverr_o),
    .m_psel_o    (m_psel_o),
    .m_penable_o (m_penable_o),
    .m_paddr_o   (m_paddr_o),
    .m_pwrite_o  (m_pwrite_o),
    .m_pwdata_o  (m_pwdata_o),
    .m_pready_i  (m_pready_i),
    .m_prdata_i  (m_prdata_i),
    .m_pslverr_i (m_pslverr_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Downstream slave models
  // ---------------------------------------------------------------------------
  logic [2:0]  hang_cfg;
  logic [2:0]  err_cfg;
  logic        noise;        // drives PREADY high on non-selected slaves
  int          wait_cfg  [3];
  logic [31:0] rdata_cfg [3];
  int          acc_cnt = 0;

  always_comb begin
    m_pready_i = '0;
    for (int k = 0; k < 3; k++) begin
      if (m_psel_o[k] && m_penable_o)
        m_pready_i[k] = !hang_cfg[k] && (acc_cnt == wait_cfg[k]);
      else
        m_pready_i[k] = noise;
    end
  end

  assign m_prdata_i  = {rdata_cfg[2], rdata_cfg[1], rdata_cfg[0]};
  assign m_pslverr_i = err_cfg;

  always @(posedge clk) begin
    if ((m_psel_o != 3'b000) && m_penable_o && ((m_psel_o & m_pready_i) == 3'b000))
      acc_cnt <= acc_cnt + 1;
    else
      acc_cnt <= 0;
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q [$];
  int   rdy_cycles [$];
  int   n_checks  = 0;
  int   n_err     = 0;
  int   pen_total = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_psel"},     64'(m_psel_o),    64'd0);
    chk({tag, "_m_penable"},  64'(m_penable_o), 64'd0);
    chk({tag, "_m_paddr"},    64'(m_paddr_o),   64'd0);
    chk({tag, "_m_pwrite"},   64'(m_pwrite_o),  64'd0);
    chk({tag, "_m_pwdata"},   64'(m_pwdata_o),  64'd0);
    chk({tag, "_s_pready"},   64'(s_pready_o),  64'd0);
    chk({tag, "_s_prdata"},   64'(s_prdata_o),  64'd0);
    chk({tag, "_s_pslverr"},  64'(s_pslverr_o), 64'd0);
  endtask

  // Monitor: response scoreboard plus per-cycle invariants.
  always @(posedge clk) begin
    #1;
    if (!rst_i) begin
      if (m_penable_o) pen_total++;
      chk("psel_onehot0", 64'($onehot0(m_psel_o)), 64'd1);
      if (s_pready_o) begin
        rdy_cycles.push_back(cyc);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_pready: got s_pready_o=1 at cycle %0d, required no response", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_prdata",  64'(s_prdata_o),  64'(mon_e.rdata));
          chk("rsp_pslverr", 64'(s_pslverr_o), 64'(mon_e.err));
          chk("rsp_cycle",   64'(cyc),         64'(mon_e.cyc));
        end
      end else begin
        chk("idle_prdata",  64'(s_prdata_o),  64'd0);
        chk("idle_pslverr", 64'(s_pslverr_o), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Upstream master: one APB transfer. Called just after a rising edge.
  // lat = cycles from the issue point to the cycle in which s_pready_o is seen.
  // ---------------------------------------------------------------------------
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [2:0] exp_sel, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat);
    exp_t e;
    int   n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + lat;
    sb_q.push_back(e);
    s_psel_i    = 1'b1;
    s_penable_i = 1'b0;
    s_paddr_i   = addr;
    s_pwrite_i  = wr;
    s_pwdata_i  = wdata;
    @(posedge clk); #1;
    chk("setup_psel", 64'(m_psel_o), 64'(exp_sel));
    s_penable_i = 1'b1;
    if (exp_sel != 3'b000) begin
      chk("setup_penable", 64'(m_penable_o), 64'd0);
      @(posedge clk); #1;
      chk("access_penable", 64'(m_penable_o), 64'd1);
      chk("access_psel",    64'(m_psel_o),    64'(exp_sel));
      chk("access_paddr",   64'(m_paddr_o),   64'(addr));
      chk("access_pwrite",  64'(m_pwrite_o),  64'(wr));
      if (wr) chk("access_pwdata", 64'(m_pwdata_o), 64'(wdata));
    end
    n = 0;
    while (!s_pready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_pready_o) begin
      n_checks++;
      n_err++;
      $display("FAIL xfer_wait: s_pready_o=0 after 40 cycles for addr 0x%0h, required 1", addr);
    end else begin
      chk("resp_psel_dropped", 64'(m_psel_o), 64'd0);
    end
    @(posedge clk); #1;
    s_psel_i    = 1'b0;
    s_penable_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int p0;
    int n0;
    s_psel_i    = 1'b0;
    s_penable_i = 1'b0;
    s_paddr_i   = '0;
    s_pwrite_i  = 1'b0;
    s_pwdata_i  = '0;
    hang_cfg    = '0;
    err_cfg     = '0;
    noise       = 1'b0;
    wait_cfg    = '{0, 0, 0};
    rdata_cfg   = '{32'h0A0A_0000, 32'h5555_AAAA, 32'hCAFE_0002};
    rst_i       = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_rst");
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("post_rst");

    // Write to slave 1, zero wait; slave drives nonzero read data, ignored
    do_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 3);

    // Read from slave 2 with 3 wait states; other slaves assert PREADY
    wait_cfg[2]  = 3;
    rdata_cfg[2] = 32'h1234_5678;
    noise        = 1'b1;
    do_xfer(32'h0000_2010, 1'b0, 32'h0, 3'b100, 32'h1234_5678, 1'b0, 6);
    noise        = 1'b0;
    wait_cfg[2]  = 0;

    // Unmapped read
    do_xfer(32'h0000_8000, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 1);

    // Slave 0 never ready: timeout after 16 ACCESS cycles
    hang_cfg[0] = 1'b1;
    p0 = pen_total;
    do_xfer(32'h0000_0000, 1'b0, 32'h0, 3'b001, 32'h0, 1'b1, 18);
    chk("timeout_access_len", 64'(pen_total - p0), 64'd16);
    hang_cfg[0] = 1'b0;

    // Window edges: top of slave 0 with one wait state, top of slave 1 with error
    wait_cfg[0]  = 1;
    rdata_cfg[0] = 32'h0000_00A5;
    do_xfer(32'h0000_0FFC, 1'b0, 32'h0, 3'b001, 32'h0000_00A5, 1'b0, 4);
    wait_cfg[0]  = 0;
    err_cfg[1]   = 1'b1;
    do_xfer(32'h0000_1FFC, 1'b0, 32'h0, 3'b010, 32'h5555_AAAA, 1'b1, 3);
    err_cfg[1]   = 1'b0;

    // Back-to-back: slave 0 write, then slave 2 read returning an error
    err_cfg[2]   = 1'b1;
    rdata_cfg[2] = 32'hCAFE_0002;
    n0 = rdy_cycles.size();
    do_xfer(32'h0000_0008, 1'b1, 32'h1111_2222, 3'b001, 32'h0, 1'b0, 3);
    do_xfer(32'h0000_2004, 1'b0, 32'h0, 3'b100, 32'hCAFE_0002, 1'b1, 3);
    err_cfg[2]   = 1'b0;
    if (rdy_cycles.size() >= n0 + 2)
      chk("b2b_gap", 64'(rdy_cycles[n0+1] - rdy_cycles[n0]), 64'd4);
    else
      chk("b2b_pulses", 64'(rdy_cycles.size() - n0), 64'd2);

    // Reset asserted in the middle of ACCESS
    hang_cfg[0] = 1'b1;
    n0 = rdy_cycles.size();
    s_psel_i    = 1'b1;
    s_penable_i = 1'b0;
    s_paddr_i   = 32'h0000_0040;
    s_pwrite_i  = 1'b1;
    s_pwdata_i  = 32'h7777_8888;
    @(posedge clk); #1;
    s_penable_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_penable", 64'(m_penable_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    s_psel_i    = 1'b0;
    s_penable_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    hang_cfg[0] = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("no_rsp_after_rst", 64'(rdy_cycles.size() - n0), 64'd0);

    // FSM is back in IDLE: a normal read completes with normal latency
    do_xfer(32'h0000_1000, 1'b0, 32'h0, 3'b010, 32'h5555_AAAA, 1'b0, 3);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
